vio_pok_filt: RTL and testbench
===============================

Name: vio_pok_filt

Overview:
- Consumer side of the VIO power-good indication, housed in the AON domain.
- Resynchronises the raw, asynchronous vio_pok from the VIO power-good detector and debounces it with separate rise and fall qualification windows.
- Produces a clean, registered power-ok level, single-cycle rise/fall event pulses and a saturating glitch counter.
- Consumed by the pinmux/IO isolation logic and by the AON status CSRs.

Parameters:
- RiseCycles, 16: consecutive synchronised-high cycles required before vio_pok_o asserts. Must be >= 1.
- FallCycles, 4: consecutive synchronised-low cycles required before vio_pok_o deasserts. Must be >= 1.
- GlitchCntW, 8: width of the saturating glitch counter.

Ports:
- clk_i, input, 1: AON clock.
- rst_i, input, 1: synchronous reset, active-high.
- vio_pok_i, input, 1: raw power-good from the VIO detector; asynchronous to clk_i.
- en_i, input, 1: filter enable; 0 forces the power-off view.
- clr_glitch_i, input, 1: clears glitch_cnt_o.
- vio_pok_o, output, 1: filtered, registered power-ok.
- rise_evt_o, output, 1: one-cycle pulse when vio_pok_o goes 0->1.
- fall_evt_o, output, 1: one-cycle pulse when vio_pok_o goes 1->0.
- busy_o, output, 1: high while in RiseChk or FallChk.
- glitch_cnt_o, output, GlitchCntW: number of aborted qualifications, saturating.

Behaviour:
- Synchroniser: 2-flop chain on vio_pok_i. Reset value 0. Its output is called pok_s.
- Counter: cnt, width $clog2(max(RiseCycles,FallCycles)+1). Loaded to 0 on every state entry.
- FSM states: Off (reset state), RiseChk, On, FallChk. All outputs are registered.
- vio_pok_o = 1 exactly when the registered state is On or FallChk.
- Off:
  - en_i & pok_s -> RiseChk.
  - Otherwise stay in Off.
- RiseChk:
  - !en_i -> Off. No glitch is counted.
  - !pok_s -> Off, glitch +1.
  - pok_s & cnt == RiseCycles-1 -> On, rise_evt_o = 1 in the following cycle.
  - Otherwise cnt +1.
- On:
  - !en_i -> Off, fall_evt_o pulses.
  - !pok_s -> FallChk.
  - Otherwise stay in On.
- FallChk:
  - !en_i -> Off, fall_evt_o pulses.
  - pok_s -> On, glitch +1. vio_pok_o never drops and no event is raised.
  - !pok_s & cnt == FallCycles-1 -> Off, fall_evt_o pulses.
  - Otherwise cnt +1.
- Events: rise_evt_o and fall_evt_o are registered. Each is high in exactly the first cycle vio_pok_o shows its new value. They are never high together.
- Latency: take edge 0 as the first clk_i edge sampling a stable raw transition.
  - vio_pok_o rises after edge RiseCycles+2.
  - vio_pok_o falls after edge FallCycles+2.
- en_i deassertion: the FSM is in Off one cycle later regardless of state or pok_s.
- Glitch counter:
  - Saturates at all-ones and never wraps.
  - clr_glitch_i zeroes it next cycle.
  - If a clear and an increment coincide, the clear wins and the result is 0.
- Reset:
  - rst_i sampled high at an edge forces, at that edge: synchroniser = 0, state = Off, cnt = 0, glitch_cnt_o = 0, all outputs 0.
  - This holds mid-qualification and with vio_pok_o = 1. No fall_evt_o is generated by reset.
- RiseCycles = 1 or FallCycles = 1: qualification completes on the first cycle in RiseChk/FallChk. No special casing is needed.

Test Plan:
- Defaults, en_i = 1, vio_pok_i 0->1 held -> vio_pok_o = 1 after edge 18, rise_evt_o high for exactly that one cycle, busy_o high for the 16 preceding cycles, glitch_cnt_o = 0.
- From On, vio_pok_i 1->0 held -> vio_pok_o = 0 after edge 6, one fall_evt_o pulse; then 1-cycle-wide high pulse on vio_pok_i (long enough to be captured by the synchroniser) -> no rise, glitch_cnt_o = 1.
- From On, vio_pok_i low for 2 cycles then high -> vio_pok_o stays 1, no events, glitch_cnt_o increments by 1.
- GlitchCntW = 2, 5 aborted rises -> glitch_cnt_o saturates at 3; clr_glitch_i asserted in the same cycle as a 6th abort -> glitch_cnt_o = 0.
- While On, drop en_i -> vio_pok_o = 0 and fall_evt_o = 1 after the next edge; re-enable with vio_pok_i high -> vio_pok_o returns after a full RiseCycles qualification.
- Assert rst_i at cnt = 10 of RiseChk, and separately while On -> all outputs 0 after the reset edge, no fall_evt_o, qualification restarts from Off after release.

Source files
------------

// File: rtl/vio_pok_filt.sv
// VIO power-good consumer: resynchronises the raw detector output, debounces it
// with independent rise/fall windows and reports events plus a glitch count.
module vio_pok_filt #(
    parameter int RiseCycles = 16,
    parameter int FallCycles = 4,
    parameter int GlitchCntW = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vio_pok_i,
    input  logic                  en_i,
    input  logic                  clr_glitch_i,
    output logic                  vio_pok_o,
    output logic                  rise_evt_o,
    output logic                  fall_evt_o,
    output logic                  busy_o,
    output logic [GlitchCntW-1:0] glitch_cnt_o
);

    localparam int MaxCycles = (RiseCycles > FallCycles) ? RiseCycles : FallCycles;
    localparam int CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0]       RiseLast  = CntW'(RiseCycles - 1);
    localparam logic [CntW-1:0]       FallLast  = CntW'(FallCycles - 1);
    localparam logic [GlitchCntW-1:0] GlitchMax = {GlitchCntW{1'b1}};

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RISE_CHK = 2'd1,
        ON       = 2'd2,
        FALL_CHK = 2'd3
    } state_e;

    logic                  sync_q1_r;
    logic                  pok_s;
    state_e                state_r;
    state_e                state_nxt_s;
    logic [CntW-1:0]       cnt_r;
    logic [CntW-1:0]       cnt_nxt_s;
    logic                  glitch_inc_s;
    logic                  pok_nxt_s;
    logic                  busy_nxt_s;
    logic [GlitchCntW-1:0] glitch_nxt_s;

    // Two-flop resynchroniser for the asynchronous detector output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1_r <= 1'b0;
            pok_s     <= 1'b0;
        end else begin
            sync_q1_r <= vio_pok_i;
            pok_s     <= sync_q1_r;
        end
    end

    // Next-state and qualification counter; cnt restarts at 0 on every state entry.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        glitch_inc_s = 1'b0;
        case (state_r)
            OFF: begin
                cnt_nxt_s = {CntW{1'b0}};
                if (en_i && pok_s) begin
                    state_nxt_s = RISE_CHK;
                end else begin
                    state_nxt_s = OFF;
                end
            end
            RISE_CHK: begin
                if (!en_i) begin
                    state_nxt_s = OFF;
                    cnt_nxt_s   = {CntW{1'b0}};
                end else if (!pok_s) begin
                    state_nxt_s  = OFF;
                    cnt_nxt_s    = {CntW{1'b0}};
                    glitch_inc_s = 1'b1;
                end else if (cnt_r == RiseLast) begin
                    state_nxt_s = ON;
                    cnt_nxt_s   = {CntW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            ON: begin
                cnt_nxt_s = {CntW{1'b0}};
                if (!en_i) begin
                    state_nxt_s = OFF;
                end else if (!pok_s) begin
                    state_nxt_s = FALL_CHK;
                end else begin
                    state_nxt_s = ON;
                end
            end
            FALL_CHK: begin
                if (!en_i) begin
                    state_nxt_s = OFF;
                    cnt_nxt_s   = {CntW{1'b0}};
                end else if (pok_s) begin
                    // Power came back before the fall qualified: output never drops.
                    state_nxt_s  = ON;
                    cnt_nxt_s    = {CntW{1'b0}};
                    glitch_inc_s = 1'b1;
                end else if (cnt_r == FallLast) begin
                    state_nxt_s = OFF;
                    cnt_nxt_s   = {CntW{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = OFF;
                cnt_nxt_s   = {CntW{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so that every output is a flop.
    always_comb begin
        pok_nxt_s  = (state_nxt_s == ON) || (state_nxt_s == FALL_CHK);
        busy_nxt_s = (state_nxt_s == RISE_CHK) || (state_nxt_s == FALL_CHK);
        if (clr_glitch_i) begin
            glitch_nxt_s = {GlitchCntW{1'b0}};
        end else if (glitch_inc_s && (glitch_cnt_o != GlitchMax)) begin
            glitch_nxt_s = glitch_cnt_o + {{(GlitchCntW-1){1'b0}}, 1'b1};
        end else begin
            glitch_nxt_s = glitch_cnt_o;
        end
    end

    // State, counter and registered outputs; reset never produces a fall event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= OFF;
            cnt_r        <= {CntW{1'b0}};
            vio_pok_o    <= 1'b0;
            rise_evt_o   <= 1'b0;
            fall_evt_o   <= 1'b0;
            busy_o       <= 1'b0;
            glitch_cnt_o <= {GlitchCntW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            vio_pok_o    <= pok_nxt_s;
            rise_evt_o   <= pok_nxt_s & ~vio_pok_o;
            fall_evt_o   <= ~pok_nxt_s & vio_pok_o;
            busy_o       <= busy_nxt_s;
            glitch_cnt_o <= glitch_nxt_s;
        end
    end

endmodule

// File: tb/tb_vio_pok_filt.sv
// Bench for vio_pok_filt: default instance plus a short-window, 2-bit-counter
// instance, both checked every cycle against a run-length model.
module tb_vio_pok_filt;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vio = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;

    logic       pok_a, rise_a, fall_a, busy_a;
    logic [7:0] gl_a;
    logic       pok_b, rise_b, fall_b, busy_b;
    logic [1:0] gl_b;

    int tests = 0;
    int fails = 0;
    int started = 0;

    always #5 clk = ~clk;

    vio_pok_filt dut (
        .clk_i(clk), .rst_i(rst), .vio_pok_i(vio), .en_i(en), .clr_glitch_i(clr),
        .vio_pok_o(pok_a), .rise_evt_o(rise_a), .fall_evt_o(fall_a),
        .busy_o(busy_a), .glitch_cnt_o(gl_a)
    );

    vio_pok_filt #(.RiseCycles(1), .FallCycles(1), .GlitchCntW(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .vio_pok_i(vio), .en_i(en), .clr_glitch_i(clr),
        .vio_pok_o(pok_b), .rise_evt_o(rise_b), .fall_evt_o(fall_b),
        .busy_o(busy_b), .glitch_cnt_o(gl_b)
    );

    // Model: level changes once the synchronised input has held the target
    // value for the entry edge plus the full window of edges.
    int m_s1[2], m_s2[2], m_lvl[2], m_hs[2], m_ls[2], m_g[2];
    int m_rise[2], m_fall[2], m_busy[2];

    task automatic model_step(input int i, input int rc, input int fc, input int gmax);
        int ps;
        int old;
        int inc;
        if (rst) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_hs[i] = 0; m_ls[i] = 0;
            m_g[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_busy[i] = 0;
            return;
        end
        ps  = m_s2[i];
        old = m_lvl[i];
        inc = 0;
        if (!en) begin
            m_lvl[i] = 0; m_hs[i] = 0; m_ls[i] = 0;
        end else if (old == 0) begin
            if (ps != 0) begin
                m_hs[i]++;
                if (m_hs[i] == rc + 1) begin
                    m_lvl[i] = 1; m_hs[i] = 0;
                end
            end else begin
                if (m_hs[i] > 0) inc = 1;
                m_hs[i] = 0;
            end
        end else begin
            if (ps == 0) begin
                m_ls[i]++;
                if (m_ls[i] == fc + 1) begin
                    m_lvl[i] = 0; m_ls[i] = 0;
                end
            end else begin
                if (m_ls[i] > 0) inc = 1;
                m_ls[i] = 0;
            end
        end
        m_rise[i] = (old == 0 && m_lvl[i] == 1) ? 1 : 0;
        m_fall[i] = (old == 1 && m_lvl[i] == 0) ? 1 : 0;
        m_busy[i] = ((m_lvl[i] == 0 && m_hs[i] > 0) || (m_lvl[i] == 1 && m_ls[i] > 0)) ? 1 : 0;
        if (clr) m_g[i] = 0;
        else if (inc != 0 && m_g[i] < gmax) m_g[i]++;
        m_s2[i] = m_s1[i];
        m_s1[i] = vio ? 1 : 0;
    endtask

    always @(posedge clk) begin
        model_step(0, 16, 4, 255);
        model_step(1, 1, 1, 3);
        started = 1;
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started != 0) begin
            tests++;
            if ({pok_a, rise_a, fall_a, busy_a} !== {m_lvl[0][0], m_rise[0][0], m_fall[0][0], m_busy[0][0]}
                || gl_a !== m_g[0][7:0]) begin
                fails++;
                $display("FAIL model_a t=%0t: got pok/rise/fall/busy=%b%b%b%b glitch=%0d, expected %0d%0d%0d%0d glitch=%0d",
                         $time, pok_a, rise_a, fall_a, busy_a, gl_a,
                         m_lvl[0], m_rise[0], m_fall[0], m_busy[0], m_g[0]);
            end
            tests++;
            if ({pok_b, rise_b, fall_b, busy_b} !== {m_lvl[1][0], m_rise[1][0], m_fall[1][0], m_busy[1][0]}
                || gl_b !== m_g[1][1:0]) begin
                fails++;
                $display("FAIL model_b t=%0t: got pok/rise/fall/busy=%b%b%b%b glitch=%0d, expected %0d%0d%0d%0d glitch=%0d",
                         $time, pok_b, rise_b, fall_b, busy_b, gl_b,
                         m_lvl[1], m_rise[1], m_fall[1], m_busy[1], m_g[1]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    int busy_n;
    int evt_n;

    initial begin
        tick(2);
        rst = 1'b0;
        check("reset_pok", {31'd0, pok_a}, 32'd0);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_glitch", {24'd0, gl_a}, 32'd0);

        // Rise qualification with default windows.
        en = 1'b1;
        tick(3);
        vio = 1'b1;
        busy_n = 0;
        for (int e = 0; e <= 18; e++) begin
            tick(1);
            if (busy_a) busy_n++;
            if (e == 17) check("rise_pok_before", {31'd0, pok_a}, 32'd0);
        end
        check("rise_pok", {31'd0, pok_a}, 32'd1);
        check("rise_evt", {31'd0, rise_a}, 32'd1);
        check("rise_busy_cycles", busy_n, 32'd16);
        check("rise_glitch", {24'd0, gl_a}, 32'd0);
        tick(1);
        check("rise_evt_width", {31'd0, rise_a}, 32'd0);

        // Qualified fall, then an aborted rise from a one-cycle pulse.
        vio = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick(1);
            if (e == 5) check("fall_pok_before", {31'd0, pok_a}, 32'd1);
        end
        check("fall_pok", {31'd0, pok_a}, 32'd0);
        check("fall_evt", {31'd0, fall_a}, 32'd1);
        tick(1);
        check("fall_evt_width", {31'd0, fall_a}, 32'd0);
        vio = 1'b1;
        tick(1);
        vio = 1'b0;
        tick(6);
        check("pulse_pok", {31'd0, pok_a}, 32'd0);
        check("pulse_glitch", {24'd0, gl_a}, 32'd1);

        // Short low dip while On: level held, no events, one glitch.
        vio = 1'b1;
        tick(20);
        check("reon_pok", {31'd0, pok_a}, 32'd1);
        vio = 1'b0;
        tick(2);
        vio = 1'b1;
        evt_n = 0;
        for (int e = 0; e < 8; e++) begin
            tick(1);
            if (rise_a || fall_a || !pok_a) evt_n++;
        end
        check("dip_no_events", evt_n, 32'd0);
        check("dip_glitch", {24'd0, gl_a}, 32'd2);

        // Enable drop while On, then full requalification.
        en = 1'b0;
        tick(1);
        check("dis_pok", {31'd0, pok_a}, 32'd0);
        check("dis_fall_evt", {31'd0, fall_a}, 32'd1);
        tick(1);
        en = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            tick(1);
            if (e == 15) check("reen_pok_before", {31'd0, pok_a}, 32'd0);
        end
        check("reen_pok", {31'd0, pok_a}, 32'd1);
        check("reen_rise_evt", {31'd0, rise_a}, 32'd1);

        // Clear, then saturation on the 2-bit instance.
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_glitch_a", {24'd0, gl_a}, 32'd0);
        check("clr_glitch_b", {30'd0, gl_b}, 32'd0);
        vio = 1'b0;
        tick(8);
        for (int p = 0; p < 5; p++) begin
            vio = 1'b1;
            tick(1);
            vio = 1'b0;
            tick(4);
        end
        check("sat_glitch_b", {30'd0, gl_b}, 32'd3);
        check("sat_glitch_a", {24'd0, gl_a}, 32'd5);
        vio = 1'b1;
        tick(1);
        vio = 1'b0;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_wins_b", {30'd0, gl_b}, 32'd0);
        check("clr_wins_a", {24'd0, gl_a}, 32'd0);
        tick(3);

        // Reset in the middle of rise qualification (cnt = 10).
        vio = 1'b1;
        tick(13);
        rst = 1'b1;
        tick(1);
        check("rst_mid_pok", {31'd0, pok_a}, 32'd0);
        check("rst_mid_busy", {31'd0, busy_a}, 32'd0);
        check("rst_mid_evt", {30'd0, rise_a, fall_a}, 32'd0);
        rst = 1'b0;
        for (int e = 0; e <= 18; e++) begin
            tick(1);
            if (e == 17) check("rst_requal_before", {31'd0, pok_a}, 32'd0);
        end
        check("rst_requal_pok", {31'd0, pok_a}, 32'd1);

        // Reset while On: no fall event.
        rst = 1'b1;
        tick(1);
        check("rst_on_pok", {31'd0, pok_a}, 32'd0);
        check("rst_on_fall", {31'd0, fall_a}, 32'd0);
        check("rst_on_pok_b", {31'd0, pok_b}, 32'd0);
        rst = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
